spi_cmd_counter: RTL and testbench

Command decoder and counter that sits directly downstream of the SPI slave on the icestick. It consumes received bytes, already in the `clk` domain, interprets them as a small command protocol, and maintains a 24-bit counter that can be cleared, stepped, loaded, free-run and read back. It also supplies the byte the SPI slave shifts out on MISO during the next transfer.

---
 rtl/spi_cmd_counter.sv | 169 ++++++++++++++++
 tb/tb_spi_cmd_counter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_counter.sv
// spi_cmd_counter: decodes bytes from the SPI slave into counter commands,
// runs a 24-bit counter (clear/step/load/free-run) and supplies the MISO byte.
module spi_cmd_counter #(
    parameter int unsigned PRESCALE_W = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce0_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic [23:0] count,
    output logic        run_en,
    output logic        cmd_err
);

    localparam int unsigned CNT_W = 24;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_CLEAR = 8'h01;
    localparam logic [7:0] OP_INC   = 8'h02;
    localparam logic [7:0] OP_LOAD  = 8'h03;
    localparam logic [7:0] OP_READ  = 8'h04;
    localparam logic [7:0] OP_RUN   = 8'h05;

    localparam logic [PRESCALE_W-1:0] PRESC_ONE  = {{(PRESCALE_W-1){1'b0}}, 1'b1};
    localparam logic [PRESCALE_W-1:0] PRESC_LAST = {PRESCALE_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_H,
        S_LOAD_M,
        S_LOAD_L,
        S_READ_M,
        S_READ_L,
        S_READ_END,
        S_RUN_ARG
    } state_t;

    state_t                r_state;
    logic [PRESCALE_W-1:0] r_presc;
    logic [15:0]           r_hold;
    logic [15:0]           r_snap;
    logic [CNT_W-1:0]      r_count;
    logic [7:0]            r_tx;
    logic                  r_run_en;
    logic                  r_cmd_err;

    logic                  w_acc;
    logic                  w_abort;
    logic                  w_tick;
    logic                  w_cmd_err_nx;
    logic                  w_run_en_nx;
    logic [7:0]            w_status;

    assign count   = r_count;
    assign tx_data = r_tx;
    assign run_en  = r_run_en;
    assign cmd_err = r_cmd_err;

    // Byte acceptance, abort, tick and the flag values STATUS should reflect after this edge
    always_comb begin
        w_acc        = rx_valid && !ce0_n;
        w_abort      = ce0_n && (r_state != S_IDLE);
        w_tick       = r_run_en && (r_presc == PRESC_LAST);
        w_cmd_err_nx = r_cmd_err;
        w_run_en_nx  = r_run_en;
        if (w_acc && (r_state == S_IDLE)) begin
            if (rx_data == OP_CLEAR) begin
                w_cmd_err_nx = 1'b0;
            end else if (rx_data > OP_RUN) begin
                w_cmd_err_nx = 1'b1;
            end
        end
        if (w_acc && (r_state == S_RUN_ARG)) begin
            w_run_en_nx = rx_data[0];
        end
        w_status = {2'b10, 4'b0000, w_cmd_err_nx, w_run_en_nx};
    end

    // Command FSM, counter, prescaler and MISO byte; later assignments take priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_presc   <= '0;
            r_hold    <= '0;
            r_snap    <= '0;
            r_count   <= '0;
            r_tx      <= 8'h80;
            r_run_en  <= 1'b0;
            r_cmd_err <= 1'b0;
        end else begin
            r_cmd_err <= w_cmd_err_nx;
            r_run_en  <= w_run_en_nx;

            if (w_acc && (r_state == S_RUN_ARG)) begin
                r_presc <= '0;
            end else if (r_run_en) begin
                r_presc <= r_presc + PRESC_ONE;
            end else begin
                r_presc <= '0;
            end

            // Tick applies unless an accepted CLEAR/INC/LOAD_L below overrides it
            if (w_tick) begin
                r_count <= r_count + 24'd1;
            end

            if (w_abort) begin
                r_state <= S_IDLE;
                r_hold  <= '0;
                r_tx    <= w_status;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_tx <= w_status;
                        if (w_acc) begin
                            case (rx_data)
                                OP_NOP:   ;
                                OP_CLEAR: r_count <= '0;
                                OP_INC:   r_count <= r_count + 24'd1;
                                OP_LOAD:  r_state <= S_LOAD_H;
                                OP_READ: begin
                                    r_snap  <= r_count[15:0];
                                    r_tx    <= r_count[23:16];
                                    r_state <= S_READ_M;
                                end
                                OP_RUN:   r_state <= S_RUN_ARG;
                                default:  ;
                            endcase
                        end
                    end
                    S_LOAD_H: if (w_acc) begin
                        r_hold[15:8] <= rx_data;
                        r_state      <= S_LOAD_M;
                    end
                    S_LOAD_M: if (w_acc) begin
                        r_hold[7:0] <= rx_data;
                        r_state     <= S_LOAD_L;
                    end
                    S_LOAD_L: if (w_acc) begin
                        r_count <= {r_hold, rx_data};
                        r_hold  <= '0;
                        r_tx    <= w_status;
                        r_state <= S_IDLE;
                    end
                    S_READ_M: if (w_acc) begin
                        r_tx    <= r_snap[15:8];
                        r_state <= S_READ_L;
                    end
                    S_READ_L: if (w_acc) begin
                        r_tx    <= r_snap[7:0];
                        r_state <= S_READ_END;
                    end
                    S_READ_END: if (w_acc) begin
                        r_tx    <= w_status;
                        r_state <= S_IDLE;
                    end
                    S_RUN_ARG: if (w_acc) begin
                        r_tx    <= w_status;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_cmd_counter.sv
// Scoreboard bench for spi_cmd_counter: driver runs a byte-protocol model and
// queues expected outputs; a monitor compares them when bytes are consumed or probed.
module tb_spi_cmd_counter;

    localparam int unsigned PW = 4;
    localparam int unsigned P  = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce0_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic [23:0] count;
    logic        run_en;
    logic        cmd_err;
    logic        probe;

    typedef struct packed {
        logic [23:0] cnt;
        logic [7:0]  tx;
        logic        run;
        logic        err;
    } exp_t;

    exp_t q[$];
    int n_pass  = 0;
    int n_total = 0;

    // Reference model: protocol-level view of the device
    int unsigned m_count;
    bit          m_run;
    bit          m_err;
    int unsigned m_phase;
    int          m_left;
    int          m_cmd;
    int unsigned m_acc;
    int unsigned m_snap;
    bit [7:0]    m_tx;

    spi_cmd_counter #(.PRESCALE_W(PW)) dut (
        .clk     (clk),
        .rst     (rst),
        .ce0_n   (ce0_n),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .tx_data (tx_data),
        .count   (count),
        .run_en  (run_en),
        .cmd_err (cmd_err)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, int unsigned act, int unsigned exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endfunction

    function automatic bit [7:0] m_status();
        return {2'b10, 4'b0000, m_err, m_run};
    endfunction

    task automatic model_reset();
        m_count = 0; m_run = 0; m_err = 0; m_phase = 0;
        m_left = 0; m_cmd = 0; m_acc = 0; m_snap = 0;
        m_tx = 8'h80;
    endtask

    // One clock edge of the model: acc = byte accepted, ce = chip enable level
    task automatic model_step(input bit acc, input bit [7:0] d, input bit ce);
        bit tick;
        bit drop;
        bit run_set;
        bit old_run;
        tick    = m_run && (m_phase == P - 1);
        drop    = 0;
        run_set = 0;
        old_run = m_run;
        if (ce && m_left > 0) m_left = 0;
        if (acc) begin
            if (m_left == 0) begin
                case (d)
                    8'h00: ;
                    8'h01: begin m_count = 0; m_err = 0; drop = 1; end
                    8'h02: begin m_count = (m_count + 1) & 24'hFFFFFF; drop = 1; end
                    8'h03: begin m_cmd = 3; m_left = 3; m_acc = 0; end
                    8'h04: begin m_cmd = 4; m_left = 3; m_snap = m_count; m_tx = 8'(m_snap >> 16); end
                    8'h05: begin m_cmd = 5; m_left = 1; end
                    default: m_err = 1;
                endcase
            end else begin
                m_left--;
                if (m_cmd == 3) begin
                    m_acc = (m_acc << 8) | d;
                    if (m_left == 0) begin
                        m_count = m_acc & 24'hFFFFFF;
                        drop = 1;
                    end
                end else if (m_cmd == 4) begin
                    if (m_left > 0) m_tx = 8'(m_snap >> (8 * (m_left - 1)));
                end else begin
                    m_run = d[0];
                    run_set = 1;
                end
            end
        end
        if (tick && !drop) m_count = (m_count + 1) & 24'hFFFFFF;
        m_phase = run_set ? 0 : (old_run ? (m_phase + 1) % P : 0);
        if (m_left == 0) m_tx = m_status();
    endtask

    // Drive one cycle on the falling edge, update the model on the rising edge
    task automatic cyc(input bit v, input bit [7:0] d, input bit ce, input bit pr);
        exp_t e;
        @(negedge clk);
        rx_valid = v;
        rx_data  = d;
        ce0_n    = ce;
        probe    = pr;
        @(posedge clk);
        model_step(v && !ce, d, ce);
        if ((v && !ce) || pr) begin
            e.cnt = 24'(m_count);
            e.tx  = m_tx;
            e.run = m_run;
            e.err = m_err;
            q.push_back(e);
        end
    endtask

    task automatic send(input bit [7:0] d);
        cyc(1'b1, d, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n, input bit ce);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, ce, 1'b1);
    endtask

    // Wait until the next accepted byte lands on a free-run tick edge, then send it
    task automatic send_on_tick(input bit [7:0] d);
        for (int i = 0; i < 2 * P && !(m_run && m_phase == P - 1); i++)
            cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check("tick_align", 32'(m_run && m_phase == P - 1), 1);
        send(d);
    endtask

    task automatic check_now(string tag);
        check({tag, "_count"}, count, m_count);
        check({tag, "_tx"}, tx_data, m_tx);
        check({tag, "_run"}, run_en, m_run);
        check({tag, "_err"}, cmd_err, m_err);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #2;
        check_now("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: compare DUT outputs after every consumed byte or probe cycle
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (!rst && ((rx_valid && !ce0_n) || probe)) begin
                #1;
                if (q.size() == 0) begin
                    check("scoreboard_empty", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("count", count, e.cnt);
                    check("tx_data", tx_data, e.tx);
                    check("run_en", run_en, e.run);
                    check("cmd_err", cmd_err, e.err);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r;
        int op;
        bit [7:0] b;
        rst = 1'b1; ce0_n = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; probe = 1'b0;
        model_reset();
        #12;
        check_now("por");
        @(negedge clk);
        rst = 1'b0;
        idle(2, 1'b0);

        // Load 0x123456 and read it back using opcode-like dummies
        send(8'h03); send(8'h12); send(8'h34); send(8'h56);
        send(8'h04); send(8'h02); send(8'h03); send(8'h04);
        check("load_value", count, 24'h123456);

        // Wrap from all-ones
        send(8'h03); send(8'hFF); send(8'hFF); send(8'hFF);
        send(8'h02);
        check("wrap", count, 24'h000000);
        send(8'h02);

        // Abort mid-load, then a fresh INC
        send(8'h03); send(8'hAA);
        idle(4, 1'b1);
        cyc(1'b1, 8'h02, 1'b1, 1'b1);
        send(8'h02);
        check("abort_inc", count, 24'h000002);

        // Bad opcode, then CLEAR
        send(8'h7F);
        check("err_tx", tx_data, 8'h82);
        send(8'h01);

        // Free-run and collisions with the tick
        send(8'h05); send(8'h01);
        idle(40, 1'b0);
        send_on_tick(8'h02);
        idle(5, 1'b0);
        send(8'h03); send(8'h00); send(8'h10);
        send_on_tick(8'h20);
        send_on_tick(8'h04);
        send(8'h00); send(8'h00); send(8'h00);
        send_on_tick(8'h01);
        send_on_tick(8'h00);
        send(8'h05); send(8'h00);
        idle(40, 1'b0);

        // Reset in the middle of a LOAD
        send(8'h05); send(8'h01);
        send(8'h03); send(8'h11);
        do_reset();
        idle(3, 1'b0);

        // Randomized traffic
        for (int it = 0; it < 400; it++) begin
            r = int'($urandom_range(0, 99));
            if (r < 8) begin
                idle(int'($urandom_range(1, 4)), 1'b1);
                cyc(1'b1, 8'($urandom), 1'b1, 1'b1);
            end else if (r < 75) begin
                op = int'($urandom_range(0, 7));
                b = (op == 7) ? 8'($urandom) : 8'(op == 6 ? 5 : op);
                send(b);
                if (b == 8'h03 || b == 8'h04 || b == 8'h05) begin
                    for (int k = 0; k < ((b == 8'h05) ? 1 : 3); k++) begin
                        if ($urandom_range(0, 19) == 0) begin
                            idle(int'($urandom_range(1, 3)), 1'b1);
                            break;
                        end
                        send(8'($urandom));
                    end
                end
            end else begin
                send(8'($urandom));
            end
            idle(int'($urandom_range(0, 3)), 1'b0);
        end

        idle(3, 1'b0);
        #2;
        check("queue_drain", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
